multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/mc_pkg.sv | 61 ++++++
 rtl/mc_out_decode.sv | 71 +++++++
 rtl/multicycle_ctrl.sv | 82 ++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller and the ALU control:
// FSM states, opcodes, ALU classes, datapath selects and the control word.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM4 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic [1:0] aluOP;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       memRead;
        logic       memWrite;
        logic       irWrite;
        logic       iorD;
        logic       regWrite;
        logic       regDst;
        logic       memToReg;
        logic       pc_en;
        logic [1:0] pcSource;
    } ctrl_t;

    function automatic logic op_is_legal(input logic [5:0] op);
        return (op == OP_LW)   || (op == OP_SW)  ||
               (op == OP_RTYPE)|| (op == OP_BEQ) ||
               (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_out_decode.sv
// Combinational state-to-control-word decoder for the multicycle FSM.
// Only FETCH (mem_ready) and BRANCH (zero) look at anything but the state.
module mc_out_decode
    import mc_pkg::*;
(
    input  state_e state,
    input  logic   mem_ready,
    input  logic   zero,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.memRead  = 1'b1;
                ctrl.aluSrcB  = SRCB_FOUR;
                ctrl.aluOP    = ALU_ADD;
                ctrl.pcSource = PC_ALU;
                ctrl.irWrite  = mem_ready;
                ctrl.pc_en    = mem_ready;
            end
            DECODE: begin
                ctrl.aluSrcB = SRCB_IMM4;
                ctrl.aluOP   = ALU_ADD;
            end
            MEMADR, ADDIEX: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
                ctrl.aluOP   = ALU_ADD;
            end
            MEMRD: begin
                ctrl.memRead = 1'b1;
                ctrl.iorD    = 1'b1;
            end
            MEMWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.memToReg = 1'b1;
            end
            MEMWR: begin
                ctrl.memWrite = 1'b1;
                ctrl.iorD     = 1'b1;
            end
            EXEC: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_REG;
                ctrl.aluOP   = ALU_FUNCT;
            end
            ALUWB: begin
                ctrl.regWrite = 1'b1;
                ctrl.regDst   = 1'b1;
            end
            ADDIWB: begin
                ctrl.regWrite = 1'b1;
            end
            BRANCH: begin
                ctrl.aluSrcA  = 1'b1;
                ctrl.aluSrcB  = SRCB_REG;
                ctrl.aluOP    = ALU_SUB;
                ctrl.pcSource = PC_ALUOUT;
                ctrl.pc_en    = zero;
            end
            JUMP: begin
                ctrl.pcSource = PC_JUMP;
                ctrl.pc_en    = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control unit: state register and next-state logic;
// the control word comes from mc_out_decode.
module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] aluOP,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       iorD,
    output logic       regWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       pc_en,
    output logic [1:0] pcSource,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_e state_q;
    state_e state_d;
    ctrl_t  ctrl;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR: state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_d = mem_ready ? MEMWB : MEMRD;
            MEMWR:  state_d = mem_ready ? FETCH : MEMWR;
            EXEC:   state_d = ALUWB;
            ADDIEX: state_d = ADDIWB;
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= FETCH;
        else        state_q <= state_d;
    end

    mc_out_decode u_dec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (ctrl)
    );

    // Reset forces FETCH, but must not load IR or PC while held.
    assign irWrite    = ctrl.irWrite & rst_n;
    assign pc_en      = ctrl.pc_en & rst_n;
    assign aluOP      = ctrl.aluOP;
    assign aluSrcA    = ctrl.aluSrcA;
    assign aluSrcB    = ctrl.aluSrcB;
    assign memRead    = ctrl.memRead;
    assign memWrite   = ctrl.memWrite;
    assign iorD       = ctrl.iorD;
    assign regWrite   = ctrl.regWrite;
    assign regDst     = ctrl.regDst;
    assign memToReg   = ctrl.memToReg;
    assign pcSource   = ctrl.pcSource;
    assign illegal_op = (state_q == DECODE) && !op_is_legal(opcode);
    assign state      = state_q;

endmodule
